// File: rtl/rst_seq_timestamp_gen_pkg.sv
// ============================================================================
// Module   : rst_seq_timestamp_gen_pkg
// Brief    : Shared state encodings and default constants for the reset
//            sequencer / timestamp generator (optional macro RST_TS_ADJ_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_timestamp_gen_pkg;

    typedef enum logic [1:0] {
        ST_INIT_WAIT = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_DONE      = 2'd2
    } seq_state_t;

    localparam int c_DEF_CH_NUM    = 6;
    localparam int c_DEF_TS_WIDTH  = 32;
    localparam int c_DEF_TS_STEP   = 8;
    localparam int c_DEF_DLY_WIDTH = 10;
    localparam int c_DEF_INIT_DLY  = 75;
    localparam int c_DEF_STAGE_DLY = 75;

    // Width of the signed timestamp adjustment before saturation
    localparam int c_ADJ_W = 8;

endpackage

`default_nettype wire

// File: rtl/rst_seq_timestamp_gen_ts_counter.sv
// ============================================================================
// Module   : rst_seq_timestamp_gen_ts_counter
// Brief    : Loadable free-running timestamp with carry-out pulse; optional
//            saturated step adjustment when RST_TS_ADJ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_timestamp_gen_ts_counter
    import rst_seq_timestamp_gen_pkg::*;
#(
    parameter int TS_WIDTH = c_DEF_TS_WIDTH,
    parameter int TS_STEP  = c_DEF_TS_STEP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ts_run,
    input  logic                      ts_load_valid,
    input  logic [TS_WIDTH-1:0]       ts_load_value,
`ifdef RST_TS_ADJ_EN
    input  logic                      ts_adj_valid,
    input  logic signed [c_ADJ_W-1:0] ts_adj_value,
`endif
    output logic [TS_WIDTH-1:0]       ts_value,
    output logic                      ts_wrap
);

    // Two guard bits: the adjusted step may exceed TS_WIDTH bits
    localparam int c_SW = TS_WIDTH + 2;
    localparam logic [c_SW-1:0] c_STEP = c_SW'(TS_STEP);

    logic [TS_WIDTH-1:0] r_ts;
    logic                r_wrap;
    logic [c_SW-1:0]     w_step;
    logic [c_SW-1:0]     w_sum;

`ifdef RST_TS_ADJ_EN
    localparam logic signed [c_SW-1:0] c_LIM = c_SW'(TS_STEP - 1);

    logic signed [c_SW-1:0] w_adj_ext;
    logic signed [c_SW-1:0] w_adj_sat;

    always_comb begin
        w_adj_ext = {{(c_SW - c_ADJ_W){ts_adj_value[c_ADJ_W-1]}}, ts_adj_value};
        w_adj_sat = w_adj_ext;
        if (w_adj_ext > c_LIM) begin
            w_adj_sat = c_LIM;
        end else if (w_adj_ext < -c_LIM) begin
            w_adj_sat = -c_LIM;
        end
        w_step = c_STEP;
        if (ts_adj_valid) begin
            w_step = c_STEP + $unsigned(w_adj_sat);
        end
    end
`else
    assign w_step = c_STEP;
`endif

    assign w_sum = {2'b00, r_ts} + w_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts   <= '0;
            r_wrap <= 1'b0;
        end else if (ts_load_valid) begin
            r_ts   <= ts_load_value;
            r_wrap <= 1'b0;
        end else if (ts_run) begin
            r_ts   <= w_sum[TS_WIDTH-1:0];
            r_wrap <= |w_sum[c_SW-1:TS_WIDTH];
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign ts_value = r_ts;
    assign ts_wrap  = r_wrap;

endmodule

`default_nettype wire

// File: rtl/rst_seq_timestamp_gen.sv
// ============================================================================
// Module   : rst_seq_timestamp_gen
// Brief    : Staggered per-channel reset release with soft re-sequence, plus
//            common timestamp (step adjustment via macro RST_TS_ADJ_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_timestamp_gen
    import rst_seq_timestamp_gen_pkg::*;
#(
    parameter int CH_NUM    = c_DEF_CH_NUM,
    parameter int TS_WIDTH  = c_DEF_TS_WIDTH,
    parameter int TS_STEP   = c_DEF_TS_STEP,
    parameter int DLY_WIDTH = c_DEF_DLY_WIDTH,
    parameter int INIT_DLY  = c_DEF_INIT_DLY,
    parameter int STAGE_DLY = c_DEF_STAGE_DLY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      soft_rst_req,
    input  logic                      ts_run,
    input  logic                      ts_load_valid,
    input  logic [TS_WIDTH-1:0]       ts_load_value,
`ifdef RST_TS_ADJ_EN
    input  logic                      ts_adj_valid,
    input  logic signed [c_ADJ_W-1:0] ts_adj_value,
`endif
    output logic [CH_NUM-1:0]         ch_rst_n,
    output logic                      all_rdy,
    output logic                      seq_busy,
    output logic [TS_WIDTH-1:0]       ts_value,
    output logic                      ts_wrap
);

    localparam int c_IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX   = c_IDX_W'(CH_NUM - 1);
    localparam logic [c_IDX_W-1:0]   c_FIRST_STG  = c_IDX_W'(1);
    localparam logic [DLY_WIDTH-1:0] c_INIT_LAST  = DLY_WIDTH'(INIT_DLY - 1);
    localparam logic [DLY_WIDTH-1:0] c_STAGE_LAST = DLY_WIDTH'(STAGE_DLY - 1);
    localparam logic                 c_SINGLE     = (CH_NUM == 1);

    seq_state_t           r_state,    w_state_nxt;
    logic [DLY_WIDTH-1:0] r_cnt,      w_cnt_nxt;
    logic [c_IDX_W-1:0]   r_idx,      w_idx_nxt;
    logic [CH_NUM-1:0]    r_ch_rst_n, w_ch_nxt;
    logic                 r_all_rdy,  w_rdy_nxt;
    logic                 r_seq_busy, w_busy_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT_WAIT;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_ch_rst_n <= '0;
            r_all_rdy  <= 1'b0;
            r_seq_busy <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_ch_rst_n <= w_ch_nxt;
            r_all_rdy  <= w_rdy_nxt;
            r_seq_busy <= w_busy_nxt;
        end
    end

    // Released bits are only ever set here; clearing happens only on soft reset
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_ch_nxt    = r_ch_rst_n;
        w_rdy_nxt   = r_all_rdy;
        w_busy_nxt  = r_seq_busy;
        if (soft_rst_req) begin
            w_state_nxt = ST_INIT_WAIT;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_ch_nxt    = '0;
            w_rdy_nxt   = 1'b0;
            w_busy_nxt  = 1'b1;
        end else begin
            case (r_state)
                ST_INIT_WAIT: begin
                    if (r_cnt == c_INIT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_ch_nxt[0] = 1'b1;
                        w_idx_nxt   = c_FIRST_STG;
                        if (c_SINGLE) begin
                            w_state_nxt = ST_DONE;
                            w_rdy_nxt   = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == c_STAGE_LAST) begin
                        w_cnt_nxt       = '0;
                        w_ch_nxt[r_idx] = 1'b1;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = ST_DONE;
                            w_rdy_nxt   = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    w_cnt_nxt = r_cnt;
                end
                default: begin
                    w_state_nxt = ST_INIT_WAIT;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign ch_rst_n = r_ch_rst_n;
    assign all_rdy  = r_all_rdy;
    assign seq_busy = r_seq_busy;

    rst_seq_timestamp_gen_ts_counter #(
        .TS_WIDTH (TS_WIDTH),
        .TS_STEP  (TS_STEP)
    ) u_ts_counter (
        .clk           (clk),
        .rst           (rst),
        .ts_run        (ts_run),
        .ts_load_valid (ts_load_valid),
        .ts_load_value (ts_load_value),
`ifdef RST_TS_ADJ_EN
        .ts_adj_valid  (ts_adj_valid),
        .ts_adj_value  (ts_adj_value),
`endif
        .ts_value      (ts_value),
        .ts_wrap       (ts_wrap)
    );

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_timestamp_gen.sv
// ============================================================================
// Module   : tb_rst_seq_timestamp_gen
// Brief    : Scoreboard bench for rst_seq_timestamp_gen at default parameters
//            (adjustment cases included when RST_TS_ADJ_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq_timestamp_gen;

    localparam int c_CH    = 6;
    localparam int c_INIT  = 75;
    localparam int c_STAGE = 75;
    localparam int c_STEP  = 8;

    typedef struct {
        logic [c_CH-1:0] ch;
        logic            rdy;
        logic            busy;
        logic [31:0]     ts;
        logic            wrap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            soft_rst_req;
    logic            ts_run;
    logic            ts_load_valid;
    logic [31:0]     ts_load_value;
`ifdef RST_TS_ADJ_EN
    logic            ts_adj_valid;
    logic signed [7:0] ts_adj_value;
`endif
    logic [c_CH-1:0] ch_rst_n;
    logic            all_rdy;
    logic            seq_busy;
    logic [31:0]     ts_value;
    logic            ts_wrap;

    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   sb_q[$];
    int     m_edges;
    longint m_ts;
    logic   m_wrap;

    always #5 clk = ~clk;

    rst_seq_timestamp_gen dut (
        .clk           (clk),
        .rst           (rst),
        .soft_rst_req  (soft_rst_req),
        .ts_run        (ts_run),
        .ts_load_valid (ts_load_valid),
        .ts_load_value (ts_load_value),
`ifdef RST_TS_ADJ_EN
        .ts_adj_valid  (ts_adj_valid),
        .ts_adj_value  (ts_adj_value),
`endif
        .ch_rst_n      (ch_rst_n),
        .all_rdy       (all_rdy),
        .seq_busy      (seq_busy),
        .ts_value      (ts_value),
        .ts_wrap       (ts_wrap)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".ch_rst_n"}, 64'(ch_rst_n), 64'd0);
        check({tag, ".all_rdy"},  64'(all_rdy),  64'd0);
        check({tag, ".seq_busy"}, 64'(seq_busy), 64'd1);
        check({tag, ".ts_value"}, 64'(ts_value), 64'd0);
        check({tag, ".ts_wrap"},  64'(ts_wrap),  64'd0);
    endtask

    // Channel k is released once INIT + k*STAGE edges have elapsed
    function automatic exp_t seq_expect(input int edges);
        exp_t e;
        for (int k = 0; k < c_CH; k++) begin
            e.ch[k] = (edges >= c_INIT + k * c_STAGE);
        end
        e.rdy  = (edges >= c_INIT + (c_CH - 1) * c_STAGE);
        e.busy = ~e.rdy;
        e.ts   = '0;
        e.wrap = 1'b0;
        return e;
    endfunction

    task automatic drive(input logic srq, input logic run, input logic lv,
                         input logic [31:0] lval, input logic av,
                         input int aval);
        exp_t   e;
        longint step;
        int     adj;
        @(negedge clk);
        rst           = 1'b0;
        soft_rst_req  = srq;
        ts_run        = run;
        ts_load_valid = lv;
        ts_load_value = lval;
`ifdef RST_TS_ADJ_EN
        ts_adj_valid  = av;
        ts_adj_value  = 8'(aval);
`endif
        m_edges = srq ? 0 : m_edges + 1;
        step = c_STEP;
`ifdef RST_TS_ADJ_EN
        adj = aval;
        if (adj > c_STEP - 1)  adj = c_STEP - 1;
        if (adj < -(c_STEP - 1)) adj = -(c_STEP - 1);
        if (av) step = c_STEP + adj;
`else
        adj = 0;
        if (av && adj != 0) step = c_STEP;
`endif
        if (lv) begin
            m_ts   = longint'(lval);
            m_wrap = 1'b0;
        end else if (run) begin
            m_ts   = m_ts + step;
            m_wrap = (m_ts >= 64'h1_0000_0000);
            m_ts   = m_ts & 64'hFFFF_FFFF;
        end else begin
            m_wrap = 1'b0;
        end
        e      = seq_expect(m_edges);
        e.ts   = m_ts[31:0];
        e.wrap = m_wrap;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("ch_rst_n", 64'(ch_rst_n), 64'(e.ch));
        check("all_rdy",  64'(all_rdy),  64'(e.rdy));
        check("seq_busy", 64'(seq_busy), 64'(e.busy));
        check("ts_value", 64'(ts_value), 64'(e.ts));
        check("ts_wrap",  64'(ts_wrap),  64'(e.wrap));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        soft_rst_req  = 1'b0;
        ts_run        = 1'b0;
        ts_load_valid = 1'b0;
        ts_load_value = '0;
`ifdef RST_TS_ADJ_EN
        ts_adj_valid  = 1'b0;
        ts_adj_value  = '0;
`endif
        m_edges = 0;
        m_ts    = 0;
        m_wrap  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");

        // Initial sequence; soft reset on edge 200 (ch0, ch1 released)
        for (int i = 1; i < 200; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0);

        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        for (int i = 0; i < 360; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);

        // Restart, then asynchronous reset in the middle of RELEASE
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        for (int i = 0; i < 200; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);
        #3;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        m_edges = 0;
        m_ts    = 0;
        m_wrap  = 1'b0;
        for (int i = 0; i < 460; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);

`ifdef RST_TS_ADJ_EN
        drive(1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 5);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 3);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, -20);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 5);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 100);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 7);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, -3);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0);
`endif

        if (sb_q.size() != 0) check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rst_seq_timestamp_gen.md
# rst_seq_timestamp_gen

Synthesizable reset sequencer and timestamp generator for the TSN emulation top level.
- Releases a parametrised number of per-channel active-low resets in staggered order after a programmable initial delay.
- Supports a soft-reset re-sequence request without a global reset.
- Maintains a free-running, loadable timestamp that advances by a fixed ns step per clock.
- Feeds every emulated chip/port channel with its reset and a common time base.

## Interface
Parameters:
- CH_NUM, 6, number of reset channels (≥1)
- TS_WIDTH, 32, timestamp width in bits
- TS_STEP, 8, ns added per clock (125 MHz nominal); 1 ≤ TS_STEP < 2^TS_WIDTH
- DLY_WIDTH, 10, width of the sequencing counter
- INIT_DLY, 75, cycles from sequence start to release of channel 0 (≥1, < 2^DLY_WIDTH)
- STAGE_DLY, 75, cycles between successive channel releases (≥1, < 2^DLY_WIDTH)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- soft_rst_req  in  1  one-cycle request to re-run the reset sequence
- ts_run  in  1  timestamp advance enable
- ts_load_valid  in  1  load timestamp this cycle
- ts_load_value  in  TS_WIDTH  value to load
- ch_rst_n  out  CH_NUM  per-channel active-low resets
- all_rdy  out  1  all channels released
- seq_busy  out  1  sequence in progress
- ts_value  out  TS_WIDTH  current timestamp
- ts_wrap  out  1  one-cycle pulse on timestamp carry-out

## Operation
Reset values:
- ch_rst_n = 0
- all_rdy = 0
- seq_busy = 1
- ts_value = 0
- ts_wrap = 0
- FSM = INIT_WAIT, seq counter = 0, channel index = 0

FSM states:
- INIT_WAIT: counts to INIT_DLY, releases ch_rst_n[0], then moves to RELEASE. If CH_NUM=1, it moves directly to DONE.
- RELEASE: counts STAGE_DLY per channel and releases ch_rst_n[idx]. After ch_rst_n[CH_NUM-1] is released it moves to DONE.
- DONE: all_rdy = 1, seq_busy = 0. Channels stay released.

Soft reset:
- soft_rst_req sampled high in any state forces, on that edge: ch_rst_n = 0, all_rdy = 0, seq_busy = 1, counter = 0, state INIT_WAIT.
- The sequence restarts from that point.
- soft_rst_req has no effect on the timestamp.

Released channels never re-assert except through rst or soft_rst_req.

Timestamp update, in priority order:
- ts_load_valid = 1: ts_value ← ts_load_value, ts_wrap = 0.
- Otherwise, ts_run = 1: ts_value ← (ts_value + TS_STEP) mod 2^TS_WIDTH. ts_wrap = carry-out of that add.
- Otherwise: ts_value holds, ts_wrap = 0.

The timestamp runs independently of the sequencer state.

## Timing
- Edge numbering: edge 1 is the first rising clk edge after rst deasserts, or the first edge after the edge that sampled soft_rst_req.
- ch_rst_n[k] rises after edge INIT_DLY + k·STAGE_DLY.
- all_rdy rises and seq_busy falls on the same edge as ch_rst_n[CH_NUM-1].
- All outputs are registered. There is no combinational path from any input to any output.
- Timestamp latency is 1 cycle: a load presented at edge E is visible after E.
- ts_wrap is high for exactly the cycle following the wrapping edge.
- rst asserted mid-sequence or mid-count returns every output to its reset value immediately (asynchronous).

## Configuration
Macro RST_TS_ADJ_EN.

Defined:
- Adds input ts_adj_valid (1 bit) and input ts_adj_value (signed, 8 bits).
- When ts_run = 1, ts_load_valid = 0 and ts_adj_valid = 1, the increment becomes TS_STEP + sat(ts_adj_value).
- sat() clamps the adjustment to ±(TS_STEP−1), so the net step is always ≥1.
- ts_wrap is the carry-out of ts_value + net step.
- The adjustment is discarded when ts_run = 0 or when a load occurs.

Undefined:
- The ports are absent and the increment is always TS_STEP.

## Structure
- Shared package/header holds:
  - FSM state encodings: INIT_WAIT, RELEASE, DONE.
  - Default parameter constants.
  - The saturation width constant for ts_adj_value.
- One natural sub-module, ts_counter: the timestamp register, load/run priority, wrap detection and the optional adjustment.
- The sequencer FSM stays in the top module.

## Test plan
- Defaults, rst released: ch_rst_n[0] rises after edge 75, ch_rst_n[5] after edge 450. all_rdy rises with ch_rst_n[5]. ch_rst_n = 6'b000000 before edge 75.
- soft_rst_req pulsed at edge 200, with ch0 and ch1 released: all ch_rst_n = 0 after edge 200. ch_rst_n[0] re-rises 75 edges later, ch_rst_n[5] 450 edges later. ts_value is unaffected.
- ts_load_valid with 0xFFFF_FFF8 and ts_run = 1 on the next edge: ts_value = 0x0000_0000, and ts_wrap is high for one cycle.
- ts_load_valid = 1 with value 0x100 while ts_run = 1: ts_value = 0x100 (load wins, no +8). The following edge gives 0x108.
- rst asserted mid-RELEASE: all outputs return to reset values asynchronously. The sequence restarts from edge 1 after deassertion.
- RST_TS_ADJ_EN, starting from ts_value = 0x1000:
  - adj = +3 gives 0x100B.
  - adj = −20, saturated to −7, gives a step of +1.
  - adj applied with ts_run = 0 leaves the value unchanged.
